// File: rtl/butterfly_pkg.sv
// butterfly_pkg: shared types, rounding/saturation helpers and scale limit for butterfly_4_pipe
package butterfly_pkg;
  localparam int SCALE_MAX = 2;
  localparam int WIDE = 64;
  typedef logic signed [WIDE-1:0] wide_t;
  typedef struct packed {
    wide_t re;
    wide_t im;
  } cplx_t;
  function automatic wide_t rnd(input wide_t t, input int frac);
    return (t + (wide_t'(1) <<< (frac - 1))) >>> frac;
  endfunction
  function automatic wide_t sat(input wide_t v, input int w);
    wide_t hi;
    hi = (wide_t'(1) <<< (w - 1)) - 1;
    return v > hi ? hi : v < -hi - 1 ? -hi - 1 : v;
  endfunction
  function automatic logic [1:0] lim(input logic [1:0] s);
    return s > 2'(SCALE_MAX) ? 2'(SCALE_MAX) : s;
  endfunction
endpackage

// File: rtl/butterfly_4_pipe_cmul_round.sv
// cmul_round: complex multiply registered in S1, rounded term registered in S2
module cmul_round import butterfly_pkg::*; #(
  parameter int FULL_WIDTH = 32,
  parameter int TW_FRAC = FULL_WIDTH / 2 - 1
) (
  input  logic                          clk,
  input  logic                          en,
  input  logic [FULL_WIDTH-1:0]         x,
  input  logic [FULL_WIDTH-1:0]         w,
  output logic signed [FULL_WIDTH/2+1:0] t_re,
  output logic signed [FULL_WIDTH/2+1:0] t_im
);
  localparam int H = FULL_WIDTH / 2;
  localparam int PW = FULL_WIDTH + 1;
  localparam int TW = H + 2;
  logic signed [H-1:0] xr, xi, wr, wi;
  logic signed [PW-1:0] p_re, p_im;
  assign {xr, xi} = x;
  assign {wr, wi} = w;
  always_ff @(posedge clk)
    if (en) begin
      p_re <= PW'(xr) * PW'(wr) - PW'(xi) * PW'(wi);
      p_im <= PW'(xi) * PW'(wr) + PW'(xr) * PW'(wi);
      t_re <= TW'(rnd(wide_t'(p_re), TW_FRAC));
      t_im <= TW'(rnd(wide_t'(p_im), TW_FRAC));
    end
endmodule

// File: rtl/butterfly_4_pipe.sv
// butterfly_4_pipe: 3-stage radix-4 DFT/IDFT butterfly; BUTTERFLY_4_PIPE_SATURATE_EN clamps instead of wrapping
module butterfly_4_pipe import butterfly_pkg::*; #(
  parameter int FULL_WIDTH = 32,
  parameter int TW_FRAC = FULL_WIDTH / 2 - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FULL_WIDTH-1:0] a,
  input  logic [FULL_WIDTH-1:0] b,
  input  logic [FULL_WIDTH-1:0] c,
  input  logic [FULL_WIDTH-1:0] d,
  input  logic [FULL_WIDTH-1:0] w0,
  input  logic [FULL_WIDTH-1:0] w1,
  input  logic [FULL_WIDTH-1:0] w2,
  input  logic [FULL_WIDTH-1:0] w3,
  input  logic [1:0]            scale,
  input  logic                  inv,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [FULL_WIDTH-1:0] out0,
  output logic [FULL_WIDTH-1:0] out1,
  output logic [FULL_WIDTH-1:0] out2,
  output logic [FULL_WIDTH-1:0] out3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  ovf,
  input  logic                  ovf_clr
);
  localparam int H = FULL_WIDTH / 2;
  localparam int TW = H + 2;
  logic en, v1, v2, inv1, inv2, pend, any_o, new_o;
  logic [1:0] sc1, sc2;
  logic [FULL_WIDTH-1:0] xs [4];
  logic [FULL_WIDTH-1:0] ws [4];
  logic signed [TW-1:0] t_re [4];
  logic signed [TW-1:0] t_im [4];
  wide_t tr [4];
  wide_t ti [4];
  wide_t h [8];
  cplx_t s [4];
  cplx_t f1, f3;
  logic signed [H-1:0] red [8];
  assign xs = '{a, b, c, d};
  assign ws = '{w0, w1, w2, w3};
  assign en = !out_valid || out_ready;
  assign in_ready = en && rst_n;
  assign new_o = en && v2 && any_o;
  genvar i;
  for (i = 0; i < 4; i++) begin : g_cm
    cmul_round #(.FULL_WIDTH(FULL_WIDTH), .TW_FRAC(TW_FRAC)) u_cm (
      .clk(clk), .en(en), .x(xs[i]), .w(ws[i]), .t_re(t_re[i]), .t_im(t_im[i])
    );
  end
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      tr[k] = wide_t'(t_re[k]);
      ti[k] = wide_t'(t_im[k]);
    end
    f1 = '{re: tr[0] + ti[1] - tr[2] - ti[3], im: ti[0] - tr[1] - ti[2] + tr[3]};
    f3 = '{re: tr[0] - ti[1] - tr[2] + ti[3], im: ti[0] + tr[1] - ti[2] - tr[3]};
    s[0] = '{re: tr[0] + tr[1] + tr[2] + tr[3], im: ti[0] + ti[1] + ti[2] + ti[3]};
    s[2] = '{re: tr[0] - tr[1] + tr[2] - tr[3], im: ti[0] - ti[1] + ti[2] - ti[3]};
    s[1] = inv2 ? f3 : f1;
    s[3] = inv2 ? f1 : f3;
    any_o = 1'b0;
    for (int j = 0; j < 8; j++) begin
      h[j] = (j % 2 == 1 ? s[j/2].im : s[j/2].re) >>> sc2;
`ifdef BUTTERFLY_4_PIPE_SATURATE_EN
      red[j] = H'(sat(h[j], H));
`else
      red[j] = H'(h[j]);
`endif
      any_o = any_o | (wide_t'(red[j]) != h[j]);
    end
  end
  // an overflow that coincides with ovf_clr is parked in pend and re-raised next cycle
  always_ff @(posedge clk)
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      ovf <= 1'b0;
      pend <= 1'b0;
      out0 <= '0;
      out1 <= '0;
      out2 <= '0;
      out3 <= '0;
    end else begin
      if (en) begin
        v1 <= in_valid;
        sc1 <= lim(scale);
        inv1 <= inv;
        v2 <= v1;
        sc2 <= sc1;
        inv2 <= inv1;
        out_valid <= v2;
        if (v2) begin
          out0 <= {red[0], red[1]};
          out1 <= {red[2], red[3]};
          out2 <= {red[4], red[5]};
          out3 <= {red[6], red[7]};
        end
      end
      ovf <= !ovf_clr && (ovf || pend || new_o);
      pend <= ovf_clr && new_o;
    end
endmodule

// File: tb/tb_butterfly_4_pipe.sv
// tb_butterfly_4_pipe: directed vectors with hand-computed expectations for butterfly_4_pipe
module tb_butterfly_4_pipe;
  logic clk = 0, rst_n = 0;
  logic [31:0] a = 0, b = 0, c = 0, d = 0;
  logic [31:0] w0 = 32'h7FFF_0000, w1 = 32'h7FFF_0000, w2 = 32'h7FFF_0000, w3 = 32'h7FFF_0000;
  logic [1:0] scale = 0;
  logic inv = 0, in_valid = 0, out_ready = 1, ovf_clr = 0;
  logic in_ready, out_valid, ovf;
  logic [31:0] out0, out1, out2, out3;
  int errs = 0, checks = 0, di = 0, mj = 0, guard = 0;
  logic acc, seen;
`ifdef BUTTERFLY_4_PIPE_SATURATE_EN
  localparam logic [31:0] SAT0 = 32'h7FFF_0000;
`else
  localparam logic [31:0] SAT0 = 32'h0000_0000;
`endif
  localparam logic [31:0] Q = 32'h4000_0000;

  butterfly_4_pipe dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3), .scale(scale), .inv(inv),
    .in_valid(in_valid), .in_ready(in_ready),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic [31:0] ia, ib, ic, id, input logic [1:0] sc, input logic iv);
    int n;
    @(negedge clk);
    a = ia; b = ib; c = ic; d = id; scale = sc; inv = iv; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1 n++;
    end
    chk("latency", n, 3);
  endtask

  task automatic outs(input logic [31:0] e0, e1, e2, e3);
    chk("out0", out0, e0);
    chk("out1", out1, e1);
    chk("out2", out2, e2);
    chk("out3", out3, e3);
  endtask

  function automatic logic [31:0] sexp(input int k);
    return 32'((k + 1) * 256) << 16;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_out0", out0, 0);
    chk("rst_out3", out3, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge clk) rst_n = 1;
    #1 chk("ready_after_rst", in_ready, 1);
    xfer(Q, 0, 0, 0, 0, 0);
    outs(Q, Q, Q, Q);
    chk("ovf_single", ovf, 0);
    xfer(Q, Q, Q, Q, 0, 0);
    outs(SAT0, 0, 0, 0);
    chk("ovf_sum", ovf, 1);
    xfer(Q, Q, Q, Q, 2, 0);
    outs(Q, 0, 0, 0);
    chk("ovf_sticky", ovf, 1);
    @(negedge clk) ovf_clr = 1;
    @(posedge clk);
    #1 ovf_clr = 0;
    chk("ovf_clr", ovf, 0);
    xfer(Q, Q, Q, Q, 3, 0);
    outs(Q, 0, 0, 0);
    chk("ovf_scale3", ovf, 0);
    xfer(0, 32'h0000_4000, 0, 0, 0, 0);
    outs(32'h0000_4000, Q, 32'h0000_C000, 32'hC000_0000);
    xfer(0, 32'h0000_4000, 0, 0, 0, 1);
    outs(32'h0000_4000, 32'hC000_0000, 32'h0000_C000, Q);
    @(negedge clk) ovf_clr = 1;
    xfer(Q, Q, Q, Q, 0, 0);
    chk("ovf_clr_wins", ovf, 0);
    ovf_clr = 0;
    @(posedge clk);
    #1 chk("ovf_reraise", ovf, 1);
    @(negedge clk) ovf_clr = 1;
    @(posedge clk);
    #1 ovf_clr = 0;
    chk("ovf_clr2", ovf, 0);
    fork
      begin
        while (di < 8 && guard < 50) begin
          @(negedge clk);
          a = sexp(di); b = 0; c = 0; d = 0; scale = 0; inv = 0; in_valid = 1;
          #1 acc = in_ready;
          @(posedge clk);
          if (acc) di++;
          guard++;
        end
        #1 in_valid = 0;
      end
      begin
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          out_ready = !(k >= 6 && k < 10);
          #1;
          if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
          if (out_valid && mj < 8) begin
            chk("stream_out0", out0, sexp(mj));
            chk("stream_out3", out3, sexp(mj));
          end
          if (out_valid && out_ready) mj++;
        end
      end
    join
    chk("stream_count", mj, 8);
    chk("stream_ovf", ovf, 0);
    out_ready = 1;
    @(negedge clk);
    a = Q; b = Q; c = Q; d = Q; scale = 0; inv = 0; in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    rst_n = 0;
    #1 chk("ready_in_rst", in_ready, 0);
    @(posedge clk);
    @(negedge clk) rst_n = 1;
    #1 chk("ready_release", in_ready, 1);
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1;
    end
    chk("no_valid_after_rst", seen, 0);
    chk("ovf_after_rst", ovf, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/butterfly_4_pipe.md
BUTTERFLY_4_PIPE -- requirements
Module: butterfly_4_pipe

Interface
REQ-001 SHALL have parameter FULL_WIDTH, default 32: packed complex word width; real in upper half, imaginary in lower half; both halves two's complement.
REQ-002 SHALL have parameter TW_FRAC, default FULL_WIDTH/2-1: twiddle fractional bits (Q1.15 at default width).
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port a, b, c, d, input, FULL_WIDTH each: time-domain samples.
REQ-006 SHALL have port w0, w1, w2, w3, input, FULL_WIDTH each: twiddles, scaled by 2^TW_FRAC.
REQ-007 SHALL have port scale, input, 2: right shift (0..2) applied after summation; value 3 is treated as 2.
REQ-008 SHALL have port inv, input, 1: 1 selects the inverse (IDFT) output mapping.
REQ-009 SHALL have port in_valid, input, 1 and port in_ready, output, 1: input handshake.
REQ-010 SHALL have port out0, out1, out2, out3, output, FULL_WIDTH each: frequency-domain results.
REQ-011 SHALL have port out_valid, output, 1 and port out_ready, input, 1: output handshake.
REQ-012 SHALL have port ovf, output, 1 and port ovf_clr, input, 1: sticky overflow flag and its clear.

Function
REQ-013 SHALL accept a transaction on a cycle with in_valid && in_ready; a, b..d, w0..w3, scale and inv are captured together.
REQ-014 SHALL be a 3-stage pipeline: S1 registers complex products; S2 registers rounded terms; S3 registers sums and outputs.
REQ-015 SHALL present the result with out_valid high exactly 3 cycles after acceptance when out_ready stays high.
REQ-016 SHALL advance all stages together on enable = !out_valid || out_ready; in_ready SHALL equal enable, with no combinational path from in_valid.
REQ-017 SHALL hold outputs stable while out_valid && !out_ready; no transaction is lost or duplicated. Full throughput is one transaction per cycle.
REQ-018 SHALL compute tk_re = xr*wr - xi*wi and tk_im = xi*wr + xr*wi at full precision (FULL_WIDTH+1 bits).
REQ-019 SHALL round each term as (t + 2^(TW_FRAC-1)) >>> TW_FRAC (round half up), kept at FULL_WIDTH/2+2 bits.
REQ-020 SHALL form, with inv=0: out0=t0+t1+t2+t3; out1 re=t0r+t1i-t2r-t3i, im=t0i-t1r-t2i+t3r; out2=t0-t1+t2-t3; out3 re=t0r-t1i-t2r+t3i, im=t0i+t1r-t2i-t3r.
REQ-021 SHALL, with inv=1, exchange out1 and out3; out0 and out2 are unchanged.
REQ-022 SHALL arithmetic-right-shift each sum by scale (truncating), then reduce it to FULL_WIDTH/2 bits per REQ-029/030.
REQ-023 SHALL set ovf when any reduced half of an emitted result differs from its pre-reduction value. ovf stays set until ovf_clr.
REQ-024 SHALL give ovf_clr priority over a new overflow in the same cycle; a new overflow sets ovf again on the next cycle.

Reset
REQ-025 SHALL on rst_n=0 clear all stage valids, out_valid, ovf and out0..out3 to 0 on the next edge.
REQ-026 SHALL drop in-flight transactions on reset mid-operation; no out_valid SHALL appear from them afterwards.
REQ-027 SHALL hold in_ready low while rst_n=0.

Configuration
REQ-028 SHALL use macro BUTTERFLY_4_PIPE_SATURATE_EN.
REQ-029 SHALL, when the macro is defined, clamp each half to [-2^(W-1), 2^(W-1)-1] (W=FULL_WIDTH/2).
REQ-030 SHALL, when the macro is undefined, wrap each half (keep the low W bits); ovf behaviour is identical in both builds.

Structure
REQ-031 SHALL place in package butterfly_pkg: complex-split typedef, round/saturate functions and the scale-limit constant.
REQ-032 SHALL instantiate four copies of sub-module cmul_round, one complex multiply with rounding across S1/S2.

Verification
REQ-033 SHALL test a=0x4000_0000, b=c=d=0, w*=0x7FFF_0000, scale=0: out0..out3=0x4000_0000 after 3 cycles, ovf=0.
REQ-034 SHALL test a=b=c=d=0x4000_0000, same twiddles, scale=0: out0 re=0x7FFF with SAT_EN, or 0x0000 without; ovf=1; out1..3=0.
REQ-035 SHALL repeat REQ-034 with scale=2: out0=0x4000_0000, ovf unchanged from prior value, out1..3=0.
REQ-036 SHALL test b=0x0000_4000, a=c=d=0, w*=0x7FFF_0000: inv=0 gives out1=0x4000_0000; inv=1 gives out3=0x4000_0000, out1=0xC000_0000.
REQ-037 SHALL stream 8 back-to-back transactions with out_ready low for 4 cycles mid-stream: in_ready falls, outputs hold, all 8 emerge in order.
REQ-038 SHALL assert rst_n=0 for 1 cycle with 2 transactions in flight: no out_valid afterwards, ovf=0, in_ready high the cycle after release.
